// File: rtl/step_control_unit.sv
// Hardwired fetch/execute sequencer: RST, T0-T7, HALT with Moore strobes.
// Define STEP_CTRL_MULDIV_EN to enable the mul/div sequence.
module step_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        IRIn,
  output logic        YIn,
  output logic        ZIn,
  output logic        HiIn,
  output logic        LoIn,
  output logic        RIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        read,
  output logic        write,
  output logic        add,
  output logic        subtract,
  output logic        andSignal,
  output logic        orSignal,
  output logic        multiply,
  output logic        divide,
  output logic        run
);

`ifdef STEP_CTRL_MULDIV_EN
  localparam logic MULDIV = 1'b1;
`else
  localparam logic MULDIV = 1'b0;
`endif

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [4:0] op;
  logic is_rtype, is_imm, is_ldi;
  logic is_ld, is_st, is_mem;
  logic is_mul, is_div, is_md;
  logic is_halt, is_exec;
  logic op_add, op_sub, op_and, op_or;
  logic unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  assign op_add = (op == OP_ADD) || (op == OP_ADDI);
  assign op_sub = (op == OP_SUB);
  assign op_and = (op == OP_AND) || (op == OP_ANDI);
  assign op_or  = (op == OP_OR)  || (op == OP_ORI);

  assign is_rtype = (op == OP_ADD) || (op == OP_SUB) ||
                    (op == OP_AND) || (op == OP_OR);
  assign is_imm   = (op == OP_ADDI) || (op == OP_ANDI) ||
                    (op == OP_ORI);
  assign is_ldi   = (op == OP_LDI);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_mem   = is_ld || is_st;
  assign is_mul   = MULDIV && (op == OP_MUL);
  assign is_div   = MULDIV && (op == OP_DIV);
  assign is_md    = is_mul || is_div;
  assign is_halt  = (op == OP_HALT);
  assign is_exec  = is_rtype || is_imm || is_ldi ||
                    is_mem || is_md;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_RST;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    Cout      = 1'b0;
    BAout     = 1'b0;
    Rout      = 1'b0;
    MARIn     = 1'b0;
    PCIn      = 1'b0;
    MDRIn     = 1'b0;
    IRIn      = 1'b0;
    YIn       = 1'b0;
    ZIn       = 1'b0;
    HiIn      = 1'b0;
    LoIn      = 1'b0;
    RIn       = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    IncPC     = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    add       = 1'b0;
    subtract  = 1'b0;
    andSignal = 1'b0;
    orSignal  = 1'b0;
    multiply  = 1'b0;
    divide    = 1'b0;
    run       = 1'b1;

    unique case (state)
      S_RST: begin
        run      = 1'b0;
        state_nx = S_T0;
      end
      S_T0: begin
        PCout    = 1'b1;
        MARIn    = 1'b1;
        IncPC    = 1'b1;
        ZIn      = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        Zlowout  = 1'b1;
        PCIn     = 1'b1;
        read     = 1'b1;
        MDRIn    = 1'b1;
        state_nx = S_T2;
      end
      S_T2: begin
        MDRout   = 1'b1;
        IRIn     = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        if (is_rtype || is_imm) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          YIn  = 1'b1;
        end else if (is_mem || is_ldi) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          YIn   = 1'b1;
        end else if (is_md) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          YIn  = 1'b1;
        end
        if (is_exec)      state_nx = S_T4;
        else if (is_halt) state_nx = S_HALT;
        else              state_nx = S_T0;
      end
      S_T4: begin
        ZIn = is_exec;
        if (is_rtype || is_imm) begin
          Grc       = is_rtype;
          Rout      = is_rtype;
          Cout      = is_imm;
          add       = op_add;
          subtract  = op_sub;
          andSignal = op_and;
          orSignal  = op_or;
        end else if (is_mem || is_ldi) begin
          Cout = 1'b1;
          add  = 1'b1;
        end else if (is_md) begin
          Grb      = 1'b1;
          Rout     = 1'b1;
          multiply = is_mul;
          divide   = is_div;
        end
        state_nx = S_T5;
      end
      S_T5: begin
        Zlowout = is_exec;
        if (is_mem) begin
          MARIn    = 1'b1;
          state_nx = S_T6;
        end else if (is_md) begin
          LoIn     = 1'b1;
          state_nx = S_T6;
        end else begin
          Gra      = is_exec;
          RIn      = is_exec;
          state_nx = S_T0;
        end
      end
      S_T6: begin
        // mul/div finish here; ld/st need one more cycle
        if (is_ld) begin
          read     = 1'b1;
          MDRIn    = 1'b1;
          state_nx = S_T7;
        end else if (is_st) begin
          Gra      = 1'b1;
          Rout     = 1'b1;
          MDRIn    = 1'b1;
          state_nx = S_T7;
        end else begin
          Zhighout = is_md;
          HiIn     = is_md;
          state_nx = S_T0;
        end
      end
      S_T7: begin
        MDRout   = is_ld;
        Gra      = is_ld;
        RIn      = is_ld;
        write    = is_st;
        state_nx = S_T0;
      end
      S_HALT: begin
        run      = 1'b0;
        state_nx = S_HALT;
      end
      default: begin
        run      = 1'b0;
        state_nx = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_step_control_unit.sv
// Self-checking bench for step_control_unit: instruction table plus
// halt and mid-instruction reset sequences.
module tb_step_control_unit;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic PCout, MDRout, Zlowout, Zhighout, Cout, BAout, Rout;
  logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn;
  logic Gra, Grb, Grc, IncPC, read, write;
  logic add, subtract, andSignal, orSignal, multiply, divide;
  logic run;

  step_control_unit dut (
    .clk(clk), .clr(clr), .ir(ir),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn),
    .YIn(YIn), .ZIn(ZIn), .HiIn(HiIn), .LoIn(LoIn), .RIn(RIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .read(read), .write(write), .add(add), .subtract(subtract),
    .andSignal(andSignal), .orSignal(orSignal),
    .multiply(multiply), .divide(divide), .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [28:0] PCOUT = 29'd1 << 0;
  localparam logic [28:0] MDROUT = 29'd1 << 1;
  localparam logic [28:0] ZLOW = 29'd1 << 2;
  localparam logic [28:0] ZHIGH = 29'd1 << 3;
  localparam logic [28:0] COUT = 29'd1 << 4;
  localparam logic [28:0] BAOUT = 29'd1 << 5;
  localparam logic [28:0] ROUT = 29'd1 << 6;
  localparam logic [28:0] MARIN = 29'd1 << 7;
  localparam logic [28:0] PCIN = 29'd1 << 8;
  localparam logic [28:0] MDRIN = 29'd1 << 9;
  localparam logic [28:0] IRIN = 29'd1 << 10;
  localparam logic [28:0] YIN = 29'd1 << 11;
  localparam logic [28:0] ZIN = 29'd1 << 12;
  localparam logic [28:0] HIIN = 29'd1 << 13;
  localparam logic [28:0] LOIN = 29'd1 << 14;
  localparam logic [28:0] RIN = 29'd1 << 15;
  localparam logic [28:0] GRA = 29'd1 << 16;
  localparam logic [28:0] GRB = 29'd1 << 17;
  localparam logic [28:0] GRC = 29'd1 << 18;
  localparam logic [28:0] INCPC = 29'd1 << 19;
  localparam logic [28:0] READ = 29'd1 << 20;
  localparam logic [28:0] WRITE = 29'd1 << 21;
  localparam logic [28:0] ADD = 29'd1 << 22;
  localparam logic [28:0] SUB = 29'd1 << 23;
  localparam logic [28:0] ANDS = 29'd1 << 24;
  localparam logic [28:0] ORS = 29'd1 << 25;
  localparam logic [28:0] MUL = 29'd1 << 26;
  localparam logic [28:0] DIV = 29'd1 << 27;
  localparam logic [28:0] RUN = 29'd1 << 28;

  localparam logic [28:0] F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [28:0] F1 = RUN | ZLOW | PCIN | READ | MDRIN;
  localparam logic [28:0] F2 = RUN | MDROUT | IRIN;
  localparam logic [28:0] RT3 = RUN | GRB | ROUT | YIN;
  localparam logic [28:0] BT3 = RUN | GRB | BAOUT | YIN;
  localparam logic [28:0] BT4 = RUN | COUT | ADD | ZIN;
  localparam logic [28:0] WB5 = RUN | ZLOW | GRA | RIN;
  localparam logic [28:0] MA5 = RUN | ZLOW | MARIN;
  localparam logic [28:0] NOP3 = RUN;

  localparam logic [31:0] I_LD   = 32'h0000_0010;
  localparam logic [31:0] I_LDI  = 32'h0800_0000;
  localparam logic [31:0] I_ST   = 32'h1000_0000;
  localparam logic [31:0] I_ADD  = 32'h1800_0000;
  localparam logic [31:0] I_SUB  = 32'h2000_0000;
  localparam logic [31:0] I_AND  = 32'h2800_0000;
  localparam logic [31:0] I_OR   = 32'h3000_0000;
  localparam logic [31:0] I_ADDI = 32'h6110_0005;
  localparam logic [31:0] I_ANDI = 32'h6800_0000;
  localparam logic [31:0] I_ORI  = 32'h7000_0000;
  localparam logic [31:0] I_MUL  = 32'h7800_0000;
  localparam logic [31:0] I_DIV  = 32'h8000_0000;
  localparam logic [31:0] I_NOP  = 32'hF800_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  typedef struct {
    logic        first;
    logic [31:0] ir;
    logic [28:0] exp;
    string       name;
  } row_t;

  row_t        rows[$];
  logic [28:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [28:0] outs();
    return {run, divide, multiply, orSignal, andSignal, subtract, add,
            write, read, IncPC, Grc, Grb, Gra, RIn, LoIn, HiIn, ZIn,
            YIn, IRIn, MDRIn, PCIn, MARIn, Rout, BAout, Cout,
            Zhighout, Zlowout, MDRout, PCout};
  endfunction

  task automatic check(input string nm, input logic [28:0] got,
                       input logic [28:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic instr(input logic [31:0] i, input string nm,
                       input int n, input logic [28:0] e3,
                       input logic [28:0] e4, input logic [28:0] e5,
                       input logic [28:0] e6, input logic [28:0] e7);
    logic [28:0] ex[8];
    ex[0] = F0; ex[1] = F1; ex[2] = F2; ex[3] = e3;
    ex[4] = e4; ex[5] = e5; ex[6] = e6; ex[7] = e7;
    for (int k = 0; k < n; k++)
      rows.push_back('{first: (k == 0), ir: i, exp: ex[k],
                       name: $sformatf("%s_t%0d", nm, k)});
  endtask

  // push expectation at drive time, pop and compare after the edge
  task automatic cyc(input logic [28:0] e, input string nm,
                     input logic set_ir, input logic [31:0] nir);
    logic [28:0] want;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (set_ir) ir = nir;
    want = sb.pop_front();
    check(nm, outs(), want);
  endtask

  initial begin
    clr = 1'b0;
    ir  = 32'h0;

    instr(I_ADDI, "addi", 6, RT3, BT4, WB5, 0, 0);
    instr(I_LD, "ld", 8, BT3, BT4, MA5, RUN | READ | MDRIN,
          RUN | MDROUT | GRA | RIN);
    instr(I_ST, "st", 8, BT3, BT4, MA5, RUN | GRA | ROUT | MDRIN,
          RUN | WRITE);
    instr(I_ADD, "add", 6, RT3, RUN | GRC | ROUT | ADD | ZIN, WB5, 0, 0);
    instr(I_SUB, "sub", 6, RT3, RUN | GRC | ROUT | SUB | ZIN, WB5, 0, 0);
    instr(I_AND, "and", 6, RT3, RUN | GRC | ROUT | ANDS | ZIN, WB5, 0, 0);
    instr(I_OR, "or", 6, RT3, RUN | GRC | ROUT | ORS | ZIN, WB5, 0, 0);
    instr(I_ANDI, "andi", 6, RT3, RUN | COUT | ANDS | ZIN, WB5, 0, 0);
    instr(I_ORI, "ori", 6, RT3, RUN | COUT | ORS | ZIN, WB5, 0, 0);
    instr(I_LDI, "ldi", 6, BT3, BT4, WB5, 0, 0);
    instr(I_NOP, "nop", 4, NOP3, 0, 0, 0, 0);
`ifdef STEP_CTRL_MULDIV_EN
    instr(I_MUL, "mul", 7, RUN | GRA | ROUT | YIN,
          RUN | GRB | ROUT | MUL | ZIN, RUN | ZLOW | LOIN,
          RUN | ZHIGH | HIIN, 0);
    instr(I_DIV, "div", 7, RUN | GRA | ROUT | YIN,
          RUN | GRB | ROUT | DIV | ZIN, RUN | ZLOW | LOIN,
          RUN | ZHIGH | HIIN, 0);
`else
    instr(I_MUL, "mul", 4, NOP3, 0, 0, 0, 0);
    instr(I_DIV, "div", 4, NOP3, 0, 0, 0, 0);
`endif
    instr(I_ADDI, "addi2", 6, RT3, BT4, WB5, 0, 0);

    #12;
    check("reset_state", outs(), 29'd0);
    @(posedge clk);
    #1;
    check("reset_hold", outs(), 29'd0);
    @(negedge clk);
    clr = 1'b1;

    foreach (rows[r])
      cyc(rows[r].exp, rows[r].name, rows[r].first, rows[r].ir);

    cyc(F0, "halt_t0", 1'b1, I_HALT);
    cyc(F1, "halt_t1", 1'b0, 32'h0);
    cyc(F2, "halt_t2", 1'b0, 32'h0);
    cyc(NOP3, "halt_t3", 1'b0, 32'h0);
    for (int k = 0; k < 20; k++)
      cyc(29'd0, $sformatf("halted_%0d", k), 1'b0, 32'h0);
    #2;
    clr = 1'b0;
    #1;
    check("halt_clr", outs(), 29'd0);
    @(negedge clk);
    clr = 1'b1;
    cyc(F0, "restart_t0", 1'b1, I_LD);
    cyc(F1, "restart_t1", 1'b0, 32'h0);
    cyc(F2, "restart_t2", 1'b0, 32'h0);
    cyc(BT3, "ldr_t3", 1'b0, 32'h0);
    cyc(BT4, "ldr_t4", 1'b0, 32'h0);
    cyc(MA5, "ldr_t5", 1'b0, 32'h0);
    #2;
    clr = 1'b0;
    #1;
    check("midld_clr", outs(), 29'd0);
    for (int k = 0; k < 3; k++)
      cyc(29'd0, $sformatf("midld_rst_%0d", k), 1'b0, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    cyc(F0, "refetch_t0", 1'b0, 32'h0);
    cyc(F1, "refetch_t1", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_control_unit.md
STEP_CONTROL_UNIT -- requirements
Module: step_control_unit

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 clr  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-003 ir  input  32  instruction from the datapath IR; the opcode is ir[31:27].
REQ-004 PCout, MDRout, Zlowout, Zhighout, Cout, BAout, Rout  output  1 each  bus-drive enables.
REQ-005 MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn  output  1 each  register load enables.
REQ-006 Gra, Grb, Grc  output  1 each  register-field select strobes.
REQ-007 IncPC, read, write  output  1 each  PC increment, memory read, memory write.
REQ-008 add, subtract, andSignal, orSignal, multiply, divide  output  1 each  ALU operation selects.
REQ-009 run  output  1  high when not halted and not in reset.

Function
REQ-010 The FSM SHALL have states RST, T0-T7 and HALT, advance at most one state per clk edge, and generate Moore outputs decoded from the state plus ir[31:27]; any output not listed for a state SHALL be 0.
REQ-011 Fetch: T0 asserts PCout, MARIn, IncPC, ZIn; T1 asserts Zlowout, PCIn, read, MDRIn; T2 asserts MDRout, IRIn; transitions are T0->T1->T2->T3 unconditionally.
REQ-012 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, halt 11011; every other opcode is a nop.
REQ-013 In T3-T7, ir SHALL be treated as stable; decode is combinational from ir[31:27].
REQ-014 R-type (add/sub/and/or): T3 Grb,Rout,YIn; T4 Grc,Rout,op,ZIn; T5 Zlowout,Gra,RIn; T5->T0.
REQ-015 Immediate (addi/andi/ori): T3 Grb,Rout,YIn; T4 Cout,op,ZIn; T5 Zlowout,Gra,RIn; T5->T0.
REQ-016 ldi: T3 Grb,BAout,YIn; T4 Cout,add,ZIn; T5 Zlowout,Gra,RIn; T5->T0.
REQ-017 ld: T3/T4 as for ldi; T5 Zlowout,MARIn; T6 read,MDRIn; T7 MDRout,Gra,RIn; T7->T0.
REQ-018 st: T3/T4 as for ldi; T5 Zlowout,MARIn; T6 Gra,Rout,MDRIn; T7 write; T7->T0.
REQ-019 nop: T3 outputs all 0; T3->T0 (4 cycles per instruction).
REQ-020 halt: T3 outputs all 0; T3->HALT; HALT holds with all outputs and run at 0 until clr is asserted.
REQ-021 The ALU select SHALL be asserted only in the cycle that asserts ZIn.
REQ-022 read and write SHALL never be asserted in the same cycle, and IncPC SHALL be asserted only in T0.

Reset
REQ-023 clr low SHALL set the state to RST and drive every output, including run, to 0 asynchronously.
REQ-024 The first clk edge with clr high SHALL move RST->T0; run SHALL be 1 from T0 onward.
REQ-025 Reset mid-instruction SHALL abandon the instruction, with no further strobes until the next T0.

Configuration
REQ-026 Macro STEP_CTRL_MULDIV_EN defined: for mul/div, T3 asserts Gra,Rout,YIn; T4 asserts Grb,Rout,multiply|divide,ZIn; T5 asserts Zlowout,LoIn; T6 asserts Zhighout,HiIn; T6->T0.
REQ-027 Macro undefined: opcodes 01111 and 10000 SHALL behave as nop, and multiply, divide, HiIn and LoIn SHALL be tied to 0.

Verification
REQ-028 Release clr, ir=32'h6110_0005 (addi) -> T0..T5 in 6 cycles; T4 shows Cout=add=ZIn=1; T5 shows Zlowout=Gra=RIn=1; back at T0.
REQ-029 ir=32'h0000_0010 (ld) -> exactly one read in T1 and one in T6; RIn only in T7; 8 cycles per instruction.
REQ-030 ir=32'h1000_0000 (st) -> write=1 only in T7; read and write are never both high.
REQ-031 ir=32'hD800_0000 (halt) -> HALT after T3; run=0; outputs stay 0 for 20 cycles; clr pulse then restarts at T0.
REQ-032 Assert clr in T5 of ld -> all outputs 0 immediately, no write or RIn afterwards; the next fetch starts at T0.
REQ-033 ir=32'h7800_0000 (mul) with and without STEP_CTRL_MULDIV_EN -> with the macro, LoIn in T5 and HiIn in T6; without it, nop timing and no multiply.
